// File: rtl/ksa12_operand_sequencer.sv
// ksa12_operand_sequencer
// Transaction front end for the 12-bit Kogge-Stone adder tree. It accepts one
// operand pair over a valid/ready stream and holds it on the adder inputs. It
// waits ADD_LATENCY clocks for S/Co to settle, captures them and offers the
// result on a valid/ready output stream. Only one operation is in flight.
//
// Optional build macro: KSA_RESULT_CHECK_EN
//   When defined, the block gets a sticky check_err output. At the capture
//   edge it compares the adder result against a behavioural add_a + add_b.
//   This is a simulation-only checker and is not meant for silicon builds.
module ksa12_operand_sequencer #(
    parameter int WIDTH       = 12,
    parameter int ADD_LATENCY = 5,   // legal range 1..15
    parameter int CNT_W       = 4    // 2**CNT_W must exceed ADD_LATENCY
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active low
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             busy
`ifdef KSA_RESULT_CHECK_EN
    ,
    output logic             check_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             capture;
    logic             handshake;

    // Accept is gated by reset through in_ready.
    assign in_ready  = (state == S_IDLE) && rst;
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;
    // The last wait clock is the one on which the counter still reads 1.
    assign capture   = (state == S_WAIT) && (cnt == CNT_W'(1));
    // out_valid is high throughout DONE, so out_ready alone completes the handshake.
    assign handshake = (state == S_DONE) && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples pre-edge values and the simulation matches the hardware.
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> WAIT on accept, WAIT -> DONE on capture, DONE -> IDLE on handshake.
    always_comb begin
        // NOTE: the default is assigned first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            S_IDLE:  if (accept)    state_next = S_WAIT;
            S_WAIT:  if (capture)   state_next = S_DONE;
            S_DONE:  if (handshake) state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    // Operand hold, wait counter and result capture.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every datapath register is cleared on reset. Reset drives
        // add_a/add_b to zero at once and discards any operation in flight.
        if (!rst) begin
            add_a     <= '0;
            add_b     <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_co    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                add_a <= in_a;
                add_b <= in_b;
                cnt   <= CNT_W'(ADD_LATENCY);
            end
            if (state == S_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                out_sum   <= add_s;
                out_co    <= add_co;
                out_valid <= 1'b1;
            end
            if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef KSA_RESULT_CHECK_EN
    // Sticky comparison of the adder result against a behavioural sum at capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            check_err <= 1'b0;
        end else if (capture &&
                     ({add_co, add_s} != ({1'b0, add_a} + {1'b0, add_b}))) begin
            check_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ksa12_operand_sequencer.sv
// Self-checking bench for ksa12_operand_sequencer. The bench acts as the
// adder: a behavioural add of add_a/add_b drives add_s/add_co. A force_bad
// switch can corrupt that result when exercising the optional checker.
module tb_ksa12_operand_sequencer;

    localparam int WIDTH = 12;
    localparam int LAT   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_co;
    logic             busy;
`ifdef KSA_RESULT_CHECK_EN
    logic             check_err;
`endif

    logic             force_bad = 1'b0;
    logic [WIDTH:0]   adder_full;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the Kogge-Stone adder (Cin = 0).
    assign adder_full = {1'b0, add_a} + {1'b0, add_b};
    assign add_s      = force_bad ? '0 : adder_full[WIDTH-1:0];
    assign add_co     = force_bad ? 1'b0 : adder_full[WIDTH];

    ksa12_operand_sequencer #(
        .WIDTH      (WIDTH),
        .ADD_LATENCY(LAT),
        .CNT_W      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_s    (add_s),
        .add_co   (add_co),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_co   (out_co),
        .busy     (busy)
`ifdef KSA_RESULT_CHECK_EN
        ,
        .check_err(check_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete operation with out_ready high. Checks the accept, the hold
    // of the operands, the exact capture cycle, the result and the return to IDLE.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_co);
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("in_ready_before_accept", in_ready, 1);
        @(negedge clk);                       // accept edge k has passed
        in_valid = 1'b0;
        check("add_a_after_accept", add_a, a);
        check("add_b_after_accept", add_b, b);
        check("in_ready_busy", in_ready, 0);
        check("busy_after_accept", busy, 1);
        for (int i = 0; i < LAT; i++) begin  // after edges k .. k+LAT-1
            check("out_valid_early", out_valid, 0);
            check("add_a_held", add_a, a);
            @(negedge clk);
        end
        check("out_valid_at_latency", out_valid, 1);   // after edge k+LAT
        check("out_sum", out_sum, exp_sum);
        check("out_co", out_co, exp_co);
        @(negedge clk);                       // handshake edge has passed
        check("out_valid_after_hs", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
        check("busy_after_hs", busy, 0);
        check("out_sum_retained", out_sum, exp_sum);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             co;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH:0]   rs;
        int               n_rand;

        // Hand-computed vectors.
        vecs[0] = '{a: 12'h0A5, b: 12'h05A, sum: 12'h0FF, co: 1'b0};
        vecs[1] = '{a: 12'hFFF, b: 12'h001, sum: 12'h000, co: 1'b1};
        vecs[2] = '{a: 12'h800, b: 12'h800, sum: 12'h000, co: 1'b1};
        vecs[3] = '{a: 12'h123, b: 12'h321, sum: 12'h444, co: 1'b0};
        vecs[4] = '{a: 12'hFFF, b: 12'hFFF, sum: 12'hFFE, co: 1'b1};
        vecs[5] = '{a: 12'h000, b: 12'h000, sum: 12'h000, co: 1'b0};
        vecs[6] = '{a: 12'h555, b: 12'hAAA, sum: 12'hFFF, co: 1'b0};
        vecs[7] = '{a: 12'h7FF, b: 12'h001, sum: 12'h800, co: 1'b0};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_co", out_co, 0);
        check("rst_busy", busy, 0);
`ifdef KSA_RESULT_CHECK_EN
        check("rst_check_err", check_err, 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", in_ready, 1);

        // Table-driven operations.
        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].co);

        // Backpressure: the result is held for 10 clocks while a new pair waits.
        @(negedge clk);
        in_a = 12'h0A5; in_b = 12'h05A; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);                       // accepted
        in_a = 12'h111; in_b = 12'h222;       // next pair, held valid
        repeat (LAT) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_sum", out_sum, 12'h0FF);
            check("bp_out_co", out_co, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_add_a_held", add_a, 12'h0A5);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);                       // handshake edge: no accept here
        check("bp_hs_out_valid", out_valid, 0);
        check("bp_hs_in_ready", in_ready, 1);
        check("bp_no_accept_on_hs", add_a, 12'h0A5);
        @(negedge clk);                       // second pair accepted
        in_valid = 1'b0;
        check("bp_second_accept_a", add_a, 12'h111);
        check("bp_second_accept_b", add_b, 12'h222);
        repeat (LAT - 1) @(negedge clk);
        check("bp_second_not_yet", out_valid, 0);
        @(negedge clk);
        check("bp_second_valid", out_valid, 1);
        check("bp_second_sum", out_sum, 12'h333);
        check("bp_second_co", out_co, 0);
        @(negedge clk);
        check("bp_second_done", out_valid, 0);

        // Reset in the middle of an operation.
        @(negedge clk);
        in_a = 12'h800; in_b = 12'h800; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);                       // accept edge k
        in_valid = 1'b0;
        check("mr_accepted", add_a, 12'h800);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_add_a_cleared", add_a, 0);
        check("mr_add_b_cleared", add_b, 0);
        check("mr_in_ready_low", in_ready, 0);
        check("mr_busy_low", busy, 0);
        repeat (2) @(negedge clk);
        check("mr_out_valid_in_reset", out_valid, 0);
        rst = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            check("mr_no_result", out_valid, 0);
        end
        check("mr_in_ready_after", in_ready, 1);
        run_op(12'h123, 12'h321, 12'h444, 1'b0);

        // Random operations against the bench's own sum.
`ifdef KSA_RESULT_CHECK_EN
        n_rand = 1000;
`else
        n_rand = 100;
`endif
        for (int i = 0; i < n_rand; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = {1'b0, ra} + {1'b0, rb};
            run_op(ra, rb, rs[WIDTH-1:0], rs[WIDTH]);
        end

`ifdef KSA_RESULT_CHECK_EN
        check("check_err_clean", check_err, 0);
        // A corrupted adder result must set the sticky error flag.
        force_bad = 1'b1;
        run_op(12'h001, 12'h001, 12'h000, 1'b0);
        force_bad = 1'b0;
        check("check_err_set", check_err, 1);
        run_op(12'h002, 12'h003, 12'h005, 1'b0);
        check("check_err_sticky", check_err, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa12_operand_sequencer.md
Name: ksa12_operand_sequencer

Overview:
- Upstream/downstream companion stage for the 12-bit Kogge-Stone adder tree.
- Accepts operand pairs over a valid/ready stream and drives them, held stable, onto the adder's A/B inputs.
- Waits a fixed number of clocks for the adder result to settle, captures S/Co, and presents the result on a valid/ready output stream.
- One operation in flight at a time; it gives the adder a clean transaction interface for the datapath.

Parameters:
- WIDTH, 12, operand/sum width; must match adder width.
- ADD_LATENCY, 5, clocks from operand change to stable adder S/Co (4 tree levels + sum layer); legal range 1..15.
- CNT_W, 4, width of wait counter; must satisfy 2**CNT_W > ADD_LATENCY.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately when low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- add_a  output  WIDTH  registered operand A to adder input A.
- add_b  output  WIDTH  registered operand B to adder input B.
- add_s  input  WIDTH  sum returned from adder S.
- add_co  input  1  carry-out returned from adder Co.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  captured sum.
- out_co  output  1  captured carry-out.
- busy  output  1  high in WAIT or DONE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, add_a=0, add_b=0, out_sum=0, out_co=0, out_valid=0, counter=0. in_ready=0 while rst is low.
- FSM states: IDLE, WAIT, DONE. in_ready = (state==IDLE) && rst. busy = (state!=IDLE).
- IDLE: on an edge with in_valid && in_ready, add_a<=in_a, add_b<=in_b, counter<=ADD_LATENCY, next state WAIT. Otherwise hold; add_a/add_b keep their last values.
- WAIT: counter decrements each edge. On the edge where counter==1: out_sum<=add_s, out_co<=add_co, out_valid<=1, next state DONE. add_a/add_b are held constant throughout WAIT.
- Latency: accept at edge k -> out_valid high after edge k+ADD_LATENCY. With ADD_LATENCY=1, the capture is on edge k+1.
- DONE: out_valid, out_sum and out_co are held stable until out_valid && out_ready is sampled at an edge. On that edge out_valid<=0 and next state is IDLE. out_sum/out_co retain their values after the handshake.
- No accept during the handshake edge. The minimum issue interval is ADD_LATENCY+2 clocks with out_ready tied high.
- in_valid while not IDLE is ignored (in_ready=0). The upstream source must hold data until the handshake; the block does not buffer.
- Arithmetic is performed entirely by the adder. The block does no addition; it copies S/Co bit-exact. The adder's Cin is 0, so out_sum = (A+B) mod 2**WIDTH and out_co = bit WIDTH of A+B.
- Reset mid-operation (WAIT or DONE): the operation is discarded, no result is emitted, and the block returns to IDLE after release.
- out_ready held high in IDLE/WAIT has no effect.

Optional Feature:
- Macro: KSA_RESULT_CHECK_EN.
- Defined: adds output check_err (1 bit, reset 0). At the capture edge the block compares {add_co,add_s} against a behavioural add_a+add_b (WIDTH+1 bits) and sets check_err<=1 on mismatch. check_err is sticky until reset. This checking logic is not synthesized for silicon builds.
- Not defined: no check_err port and no comparison logic; all other behaviour is identical.

Test Plan:
- Reset then in_a=12'h0A5, in_b=12'h05A, in_valid pulse, out_ready=1 -> out_valid high exactly 5 clocks after accept, out_sum=12'h0FF, out_co=0.
- in_a=12'hFFF, in_b=12'h001 -> out_sum=12'h000, out_co=1. Full carry propagation across all 12 bits.
- out_ready=0 for 10 clocks after out_valid with in_valid held high on a new pair -> result stable, in_ready=0, second pair accepted only on the cycle after the out handshake.
- Pull rst low 2 clocks after accepting 12'h800+12'h800 -> out_valid never asserts, add_a=add_b=0 immediately; after release in_ready=1 and next op 12'h123+12'h321 gives 12'h444, co=0.
- With KSA_RESULT_CHECK_EN and the bench forcing add_s to 12'h000 for 12'h001+12'h001 -> check_err=1 after capture and stays 1; without forcing, random 1000 ops -> check_err stays 0.
